// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags, FWFT or registered read; define SYNC_FIFO_ERR_EN for sticky overflow/underflow.
// Latency: written word visible on dout next cycle (FWFT=1); dout loads one cycle after an accepted read (FWFT=0).
// Backpressure: writes dropped while full, reads ignored while empty; read wins over write when full.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    parameter bit FWFT          = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Flags decode the registered count only, so they never depend on this cycle's inputs.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
    end

    generate
        if (FWFT) begin : g_fwft
            assign dout = mem[rd_ptr[ADDR_WIDTH-1:0]];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst)         dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            assign dout = dout_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_EN
    // A new error event outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow <= 1'b1;
            else if (err_clr)   overflow <= 1'b0;
            if (rd_en && empty) underflow <= 1'b1;
            else if (err_clr)   underflow <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds, and selectable first-word-fall-through or registered read mode. It is the general-purpose buffer between same-clock producer and consumer stages, replacing the plain full/empty FIFO wherever back-pressure needs early warning or a registered output.

## Interface
- DATA_WIDTH, 8, data word width in bits
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries
- AFULL_THRESH, 14, almost_full asserts when count >= this; legal 1..DEPTH-1
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this; legal 0..DEPTH-1
- FWFT, 1, 1 = first-word-fall-through read; 0 = registered read
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read request / pop
- dout  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- err_clr  in  1  clears sticky error flags
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; memory index = low ADDR_WIDTH bits; wrap is natural modulo 2**(ADDR_WIDTH+1).
- count is a dedicated register: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty; both judged on pre-edge state.
- Simultaneous wr_en and rd_en when full: read accepted, write rejected. When empty: write accepted, read rejected. Otherwise both accepted, count unchanged.
- full, empty, almost_full, almost_empty are combinational decodes of registered count only (no input dependence).
- FWFT=1: dout = mem[rd_ptr] combinationally; valid whenever empty=0; rd_en acknowledges the shown word. dout is don't-care while empty.
- FWFT=0: dout is a register loaded with mem[rd_ptr] on an accepted read; holds last read value otherwise; rejected reads leave it unchanged.
- Memory array is not reset.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout=0 when FWFT=0 (undefined when FWFT=1). Pointers to 0.
- rst mid-operation discards contents in one cycle; rst has priority over wr_en/rd_en.
- Write-to-read latency: FWFT=1, word on dout and empty=0 the cycle after the accepting edge; FWFT=0, data on dout the cycle after the accepting rd_en edge.
- Flags update one cycle after the accepting edge, together with count.

## Configuration
- SYNC_FIFO_ERR_EN defined: overflow sets on any edge with wr_en && full; underflow sets on any edge with rd_en && empty; both clear on rst or err_clr; set beats err_clr in the same cycle. Rejected accesses never corrupt state.
- SYNC_FIFO_ERR_EN undefined: no error registers; overflow and underflow tied 0; err_clr ignored.

## Test plan
- Defaults, FWFT=1: write 0x01..0x10 (16 words) -> full=1, count=16, almost_full from count=14; read 16 -> dout 0x01..0x10 in order, empty=1 after last.
- Full, wr_en=rd_en=1 with din=0xAA -> one word popped, 0xAA not stored, count=15; with SYNC_FIFO_ERR_EN overflow=1 until err_clr.
- Empty, wr_en=rd_en=1 with din=0x55 -> count=1, next cycle dout=0x55; with SYNC_FIFO_ERR_EN underflow=1.
- Steady wr+rd for 40 cycles at count=5 (pointer wrap twice) -> count stays 5, data order preserved, no flag toggles.
- FWFT=0: write 0x3C, 0x7E; pulse rd_en -> dout=0x3C one cycle later and held; second pulse -> 0x7E; rd_en while empty -> dout stays 0x7E.
- rst asserted at count=9 -> next cycle count=0, empty=1, almost_empty=1, overflow=underflow=0, dout=0 (FWFT=0).
